// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
//   PIPE_*_W    : default widths for instruction/PC/data, GRF address and Tnew
//   NOP_INSTR   : instruction word inserted as a bubble
//   tnew_op_e   : control code for the Tnew counter
//   sat_dec     : decrement that stops at zero
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_ADDR_W = 5;
  localparam int unsigned PIPE_TNEW_W = 2;

  localparam logic [31:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    TNEW_CLEAR,
    TNEW_LOAD,
    TNEW_HOLD,
    TNEW_AGE
  } tnew_op_e;

  // Operates on 32 bits; callers zero-extend and truncate back to their width,
  // so the result never wraps as long as the field is at most 32 bits wide.
  function automatic logic [31:0] sat_dec(input logic [31:0] x);
    return (x == '0) ? '0 : x - 32'd1;
  endfunction

endpackage

// File: rtl/pipe_tnew_ctr.sv
// Tnew register for one pipeline stage.
//   clk, reset : clock, synchronous active-low reset
//   op         : clear / load (with age) / hold / age in place
//   tnew_in    : incoming Tnew, aged by one cycle on load
//   tnew_q     : stored Tnew
module pipe_tnew_ctr
  import pipe_pkg::*;
#(
  parameter int unsigned TNEW_W = PIPE_TNEW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  tnew_op_e          op,
  input  logic [TNEW_W-1:0] tnew_in,
  output logic [TNEW_W-1:0] tnew_q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tnew_q <= '0;
    end else begin
      case (op)
        TNEW_CLEAR: tnew_q <= '0;
        TNEW_LOAD:  tnew_q <= TNEW_W'(sat_dec(32'(tnew_in)));
        TNEW_AGE:   tnew_q <= TNEW_W'(sat_dec(32'(tnew_q)));
        default:    tnew_q <= tnew_q;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register between two adjacent MIPS stages.
//   clk, reset          : clock, synchronous active-low reset
//   Stall / Flush       : hold contents / insert bubble (flush wins)
//   ValidIn, *In        : incoming slot and its payload
//   ValidOut, *Out      : registered slot and payload
//   FwdValid/FwdPending : forwarding status derived from stored state only
//   FwdAddr / FwdData   : forwarding destination and value
//   StallCnt            : saturating count of stalled cycles
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W       = PIPE_DATA_W,
  parameter int unsigned ADDR_W       = PIPE_ADDR_W,
  parameter int unsigned TNEW_W       = PIPE_TNEW_W,
  parameter int unsigned SIDE_W       = 8,
  parameter int unsigned STALLCNT_W   = 16,
  parameter bit          AGE_ON_STALL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  ValidIn,
  input  logic [DATA_W-1:0]     InstrIn,
  input  logic [DATA_W-1:0]     curPCIn,
  input  logic [DATA_W-1:0]     WDataIn,
  input  logic [ADDR_W-1:0]     WriteAddrIn,
  input  logic                  RegWriteIn,
  input  logic [TNEW_W-1:0]     TnewIn,
  input  logic [SIDE_W-1:0]     SideIn,
  output logic [DATA_W-1:0]     InstrOut,
  output logic [DATA_W-1:0]     curPCOut,
  output logic [DATA_W-1:0]     WDataOut,
  output logic [ADDR_W-1:0]     WriteAddrOut,
  output logic                  RegWriteOut,
  output logic [TNEW_W-1:0]     TnewOut,
  output logic [SIDE_W-1:0]     SideOut,
  output logic                  ValidOut,
  output logic                  FwdValid,
  output logic                  FwdPending,
  output logic [ADDR_W-1:0]     FwdAddr,
  output logic [DATA_W-1:0]     FwdData,
  output logic [STALLCNT_W-1:0] StallCnt
);

  tnew_op_e tnew_op;
  logic     bubble;

  // A flush or an empty incoming slot both produce a bubble.
  always_comb begin
    bubble  = Flush || (!Stall && !ValidIn);
    tnew_op = TNEW_LOAD;
    if (bubble)
      tnew_op = TNEW_CLEAR;
    else if (Stall)
      tnew_op = AGE_ON_STALL ? TNEW_AGE : TNEW_HOLD;
  end

  pipe_tnew_ctr #(
    .TNEW_W (TNEW_W)
  ) u_tnew (
    .clk     (clk),
    .reset   (reset),
    .op      (tnew_op),
    .tnew_in (TnewIn),
    .tnew_q  (TnewOut)
  );

  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      InstrOut     <= DATA_W'(NOP_INSTR);
      curPCOut     <= '0;
      WDataOut     <= '0;
      WriteAddrOut <= '0;
      RegWriteOut  <= 1'b0;
      SideOut      <= '0;
      ValidOut     <= 1'b0;
    end else if (!Stall) begin
      InstrOut     <= InstrIn;
      curPCOut     <= curPCIn;
      WDataOut     <= WDataIn;
      WriteAddrOut <= WriteAddrIn;
      // Writes to $0 are dropped here so consumers never forward from $0.
      RegWriteOut  <= RegWriteIn && (WriteAddrIn != '0);
      SideOut      <= SideIn;
      ValidOut     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      StallCnt <= '0;
    else if (Stall && !Flush && (StallCnt != '1))
      StallCnt <= StallCnt + 1'b1;
  end

  always_comb begin
    FwdValid   = ValidOut && RegWriteOut && (TnewOut == '0);
    FwdPending = ValidOut && RegWriteOut && (TnewOut != '0);
    FwdAddr    = WriteAddrOut;
    FwdData    = WDataOut;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        Stall, Flush, ValidIn, RegWriteIn;
  logic [31:0] InstrIn, curPCIn, WDataIn;
  logic [4:0]  WriteAddrIn;
  logic [1:0]  TnewIn;
  logic [7:0]  SideIn;

  // a_: AGE_ON_STALL=1 (defaults), h_: AGE_ON_STALL=0, s_: STALLCNT_W=2
  logic [31:0] a_instr, a_pc, a_wdata, a_fdata, h_instr, h_pc, h_wdata, h_fdata, s_instr, s_pc, s_wdata, s_fdata;
  logic [4:0]  a_waddr, a_faddr, h_waddr, h_faddr, s_waddr, s_faddr;
  logic        a_rw, a_valid, a_fv, a_fp, h_rw, h_valid, h_fv, h_fp, s_rw, s_valid, s_fv, s_fp;
  logic [1:0]  a_tnew, h_tnew, s_tnew;
  logic [7:0]  a_side, h_side, s_side;
  logic [15:0] a_scnt, h_scnt;
  logic [1:0]  s_scnt;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  pipe_stage_reg u_age (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .InstrIn(InstrIn), .curPCIn(curPCIn), .WDataIn(WDataIn), .WriteAddrIn(WriteAddrIn),
    .RegWriteIn(RegWriteIn), .TnewIn(TnewIn), .SideIn(SideIn),
    .InstrOut(a_instr), .curPCOut(a_pc), .WDataOut(a_wdata), .WriteAddrOut(a_waddr),
    .RegWriteOut(a_rw), .TnewOut(a_tnew), .SideOut(a_side), .ValidOut(a_valid),
    .FwdValid(a_fv), .FwdPending(a_fp), .FwdAddr(a_faddr), .FwdData(a_fdata), .StallCnt(a_scnt)
  );

  pipe_stage_reg #(.AGE_ON_STALL(1'b0)) u_hold (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .InstrIn(InstrIn), .curPCIn(curPCIn), .WDataIn(WDataIn), .WriteAddrIn(WriteAddrIn),
    .RegWriteIn(RegWriteIn), .TnewIn(TnewIn), .SideIn(SideIn),
    .InstrOut(h_instr), .curPCOut(h_pc), .WDataOut(h_wdata), .WriteAddrOut(h_waddr),
    .RegWriteOut(h_rw), .TnewOut(h_tnew), .SideOut(h_side), .ValidOut(h_valid),
    .FwdValid(h_fv), .FwdPending(h_fp), .FwdAddr(h_faddr), .FwdData(h_fdata), .StallCnt(h_scnt)
  );

  pipe_stage_reg #(.STALLCNT_W(2)) u_sc2 (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .InstrIn(InstrIn), .curPCIn(curPCIn), .WDataIn(WDataIn), .WriteAddrIn(WriteAddrIn),
    .RegWriteIn(RegWriteIn), .TnewIn(TnewIn), .SideIn(SideIn),
    .InstrOut(s_instr), .curPCOut(s_pc), .WDataOut(s_wdata), .WriteAddrOut(s_waddr),
    .RegWriteOut(s_rw), .TnewOut(s_tnew), .SideOut(s_side), .ValidOut(s_valid),
    .FwdValid(s_fv), .FwdPending(s_fp), .FwdAddr(s_faddr), .FwdData(s_fdata), .StallCnt(s_scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_age"}, 64'(|{a_instr, a_pc, a_wdata, a_fdata, a_waddr, a_faddr, a_rw, a_valid,
                               a_fv, a_fp, a_tnew, a_side, a_scnt}), 64'd0);
    check({tag, "_hold"}, 64'(|{h_instr, h_pc, h_wdata, h_fdata, h_waddr, h_faddr, h_rw, h_valid,
                                h_fv, h_fp, h_tnew, h_side, h_scnt}), 64'd0);
    check({tag, "_sc2"}, 64'(|{s_instr, s_pc, s_wdata, s_fdata, s_waddr, s_faddr, s_rw, s_valid,
                               s_fv, s_fp, s_tnew, s_side, s_scnt}), 64'd0);
  endtask

  initial begin
    reset = 1'b0; Stall = 1'b0; Flush = 1'b0; ValidIn = 1'b0; RegWriteIn = 1'b0;
    InstrIn = 32'h0; curPCIn = 32'h0; WDataIn = 32'h0; WriteAddrIn = 5'd0; TnewIn = 2'd0; SideIn = 8'h0;

    // Reset: everything zero
    tick();
    check_all_zero("reset");

    // Load with Tnew=2 -> stored as 1, result pending
    reset = 1'b1; ValidIn = 1'b1; RegWriteIn = 1'b1; WriteAddrIn = 5'd5; WDataIn = 32'h1234;
    TnewIn = 2'd2; InstrIn = 32'h2008_0005; curPCIn = 32'h0000_3000; SideIn = 8'hA5;
    tick();
    check("ld_valid", 64'(a_valid), 64'd1);
    check("ld_tnew", 64'(a_tnew), 64'd1);
    check("ld_fp", 64'(a_fp), 64'd1);
    check("ld_fv", 64'(a_fv), 64'd0);
    check("ld_instr", 64'(a_instr), 64'h2008_0005);
    check("ld_pc", 64'(a_pc), 64'h3000);
    check("ld_side", 64'(a_side), 64'hA5);
    check("ld_faddr", 64'(a_faddr), 64'd5);
    check("ld_hold_tnew", 64'(h_tnew), 64'd1);

    // Stall 1: inputs change but must be ignored
    Stall = 1'b1; ValidIn = 1'b0; InstrIn = 32'h1111_1111; WDataIn = 32'h9999; TnewIn = 2'd3;
    tick();
    check("st1_age_tnew", 64'(a_tnew), 64'd0);
    check("st1_age_fv", 64'(a_fv), 64'd1);
    check("st1_age_fp", 64'(a_fp), 64'd0);
    check("st1_age_fdata", 64'(a_fdata), 64'h1234);
    check("st1_age_instr", 64'(a_instr), 64'h2008_0005);
    check("st1_age_valid", 64'(a_valid), 64'd1);
    check("st1_age_cnt", 64'(a_scnt), 64'd1);
    check("st1_hold_tnew", 64'(h_tnew), 64'd1);
    check("st1_hold_fv", 64'(h_fv), 64'd0);
    check("st1_sc2_cnt", 64'(s_scnt), 64'd1);

    // Stall 2: aged Tnew stays at 0
    tick();
    check("st2_age_tnew", 64'(a_tnew), 64'd0);
    check("st2_hold_tnew", 64'(h_tnew), 64'd1);
    check("st2_hold_fv", 64'(h_fv), 64'd0);
    check("st2_sc2_cnt", 64'(s_scnt), 64'd2);

    // Stall 3
    tick();
    check("st3_hold_tnew", 64'(h_tnew), 64'd1);
    check("st3_hold_fv", 64'(h_fv), 64'd0);
    check("st3_hold_cnt", 64'(h_scnt), 64'd3);
    check("st3_sc2_cnt", 64'(s_scnt), 64'd3);

    // Stall 4, 5: 2-bit counter saturates
    tick();
    check("st4_sc2_cnt", 64'(s_scnt), 64'd3);
    check("st4_age_cnt", 64'(a_scnt), 64'd4);
    tick();
    check("st5_sc2_cnt", 64'(s_scnt), 64'd3);
    check("st5_age_cnt", 64'(a_scnt), 64'd5);

    // Flush and Stall together: bubble, counter unchanged
    Flush = 1'b1;
    tick();
    check("fl_valid", 64'(a_valid), 64'd0);
    check("fl_instr", 64'(a_instr), 64'd0);
    check("fl_rw", 64'(a_rw), 64'd0);
    check("fl_wdata", 64'(a_wdata), 64'd0);
    check("fl_tnew", 64'(h_tnew), 64'd0);
    check("fl_age_cnt", 64'(a_scnt), 64'd5);
    check("fl_sc2_cnt", 64'(s_scnt), 64'd3);

    // Reset while stalling: reset wins
    Flush = 1'b0; Stall = 1'b1; reset = 1'b0;
    tick();
    check_all_zero("rst_stall");

    // Write to $0 is dropped
    reset = 1'b1; Stall = 1'b0; ValidIn = 1'b1; RegWriteIn = 1'b1; WriteAddrIn = 5'd0;
    TnewIn = 2'd0; WDataIn = 32'h55; InstrIn = 32'h0000_0020;
    tick();
    check("r0_valid", 64'(a_valid), 64'd1);
    check("r0_rw", 64'(a_rw), 64'd0);
    check("r0_fv", 64'(a_fv), 64'd0);
    check("r0_fp", 64'(a_fp), 64'd0);
    check("r0_tnew", 64'(a_tnew), 64'd0);

    // Tnew max loads as max-1
    WriteAddrIn = 5'd7; TnewIn = 2'd3; WDataIn = 32'h77;
    tick();
    check("tmax_tnew", 64'(a_tnew), 64'd2);
    check("tmax_fp", 64'(a_fp), 64'd1);
    check("tmax_rw", 64'(a_rw), 64'd1);

    // Empty slot with nonzero instruction -> bubble
    ValidIn = 1'b0; InstrIn = 32'hDEAD_BEEF; RegWriteIn = 1'b1;
    tick();
    check("bub_instr", 64'(a_instr), 64'd0);
    check("bub_rw", 64'(a_rw), 64'd0);
    check("bub_valid", 64'(a_valid), 64'd0);
    check("bub_tnew", 64'(a_tnew), 64'd0);
    check("bub_fp", 64'(a_fp), 64'd0);

    // Tnew=1 loads as 0, then stalling keeps it at 0 in both modes
    ValidIn = 1'b1; TnewIn = 2'd1; WriteAddrIn = 5'd9; WDataIn = 32'hABCD;
    tick();
    check("t1_tnew", 64'(a_tnew), 64'd0);
    check("t1_fv", 64'(a_fv), 64'd1);
    Stall = 1'b1;
    tick();
    check("t1s_age_tnew", 64'(a_tnew), 64'd0);
    check("t1s_hold_tnew", 64'(h_tnew), 64'd0);
    check("t1s_fdata", 64'(a_fdata), 64'hABCD);
    check("t1s_sc2_cnt", 64'(s_scnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, superseding the fixed per-stage registers (D/E, E/M, M/W). It carries instruction, PC, write-back data/address and hazard metadata across one stage boundary. It adds stall (hold), flush (bubble insert), a valid bit, a configurable Tnew ageing mode and a forwarding-source port. It also keeps a saturating stall-cycle counter. One instance sits between each pair of adjacent stages; the hazard unit drives Stall/Flush.

## Interface
Parameters:
- DATA_W, 32, width of instruction, PC and write data
- ADDR_W, 5, GRF write-address width
- TNEW_W, 2, Tnew width
- SIDE_W, 8, opaque sideband payload width (control bits for later stages); must be ≥1
- STALLCNT_W, 16, stall-counter width
- AGE_ON_STALL, 1, 1: Tnew keeps counting down while held; 0: Tnew frozen while held

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state
- Stall  in  1  hold current contents
- Flush  in  1  replace contents with bubble
- ValidIn  in  1  incoming slot holds a real instruction
- InstrIn / InstrOut  in/out  DATA_W  instruction word
- curPCIn / curPCOut  in/out  DATA_W  PC of instruction
- WDataIn / WDataOut  in/out  DATA_W  GRF write data
- WriteAddrIn / WriteAddrOut  in/out  ADDR_W  GRF destination
- RegWriteIn / RegWriteOut  in/out  1  GRF write enable
- TnewIn / TnewOut  in/out  TNEW_W  cycles until result available
- SideIn / SideOut  in/out  SIDE_W  sideband payload
- ValidOut  out  1  stage holds a real instruction
- FwdValid  out  1  this stage can forward WDataOut now
- FwdPending  out  1  this stage will write a register but its result is not ready yet
- FwdAddr  out  ADDR_W  forwarding destination (= WriteAddrOut)
- FwdData  out  DATA_W  forwarding data (= WDataOut)
- StallCnt  out  STALLCNT_W  saturating count of stalled cycles

## Operation
- Per-edge priority: reset==0 > Flush > Stall > load.
- Reset: every stored field 0, StallCnt 0.
- Flush, or load with ValidIn==0: bubble.
  - All payload fields, Valid, RegWrite and Tnew are set to 0.
  - Bubble Instr = 0, i.e. a nop.
- Stall (no Flush): payload, Valid and RegWrite held.
  - Tnew = sat_dec(Tnew) if AGE_ON_STALL=1, else held.
- Load:
  - Valid ← 1; all payload fields ← inputs.
  - Tnew ← sat_dec(TnewIn).
  - RegWrite ← RegWriteIn & (WriteAddrIn != 0).
- sat_dec(x) = (x==0) ? 0 : x−1, computed in TNEW_W bits; never wraps.
- RegWriteOut is the stored bit. It is always 0 when ValidOut==0.
- FwdValid = ValidOut & RegWriteOut & (TnewOut==0).
- FwdPending = ValidOut & RegWriteOut & (TnewOut!=0).
- StallCnt increments on each edge with reset==1, Stall==1, Flush==0. It saturates at all-ones and is cleared only by reset.

## Timing
- Data outputs are registered: one-cycle latency from inputs.
- FwdValid/FwdPending/FwdAddr/FwdData are combinational from state only, with no input-to-output path.
- Reset value of every output is 0, including FwdValid, FwdPending and StallCnt.
- Flush and Stall both high: flush wins; StallCnt does not increment.
- Stall during reset==0: reset wins; StallCnt stays 0.
- Reset mid-stall: contents cleared next edge; Stall is ignored that cycle.
- Tnew at 0 under repeated stall/load stays 0.
- Tnew = 2^TNEW_W−1 loads as 2^TNEW_W−2.

## Structure
- Shared package pipe_pkg holds:
  - default width constants (DATA_W=32, ADDR_W=5, TNEW_W=2)
  - bubble/nop constant
  - sat_dec function
- One natural sub-module, pipe_tnew_ctr: the Tnew register with load/hold/age/clear controls and saturating decrement.
- Top level holds the payload registers, the valid/regwrite gating, the forwarding logic and StallCnt.

## Test plan
- Load: ValidIn=1, RegWriteIn=1, WriteAddrIn=5, WDataIn=0x1234, TnewIn=2 → next cycle ValidOut=1, TnewOut=1, FwdPending=1, FwdValid=0. After one Stall cycle with AGE_ON_STALL=1: TnewOut=0, FwdValid=1, FwdData=0x1234.
- Same load with AGE_ON_STALL=0 and 3 stall cycles → TnewOut stays 1, FwdValid=0 throughout, StallCnt=3.
- WriteAddrIn=0, RegWriteIn=1 → RegWriteOut=0, FwdValid=0, FwdPending=0.
- Flush and Stall high together on a valid slot → next cycle ValidOut=0, InstrOut=0, RegWriteOut=0, StallCnt unchanged.
- STALLCNT_W=2, 5 consecutive stall cycles → StallCnt sequence 1,2,3,3,3. Then reset=0 for one edge → all outputs 0.
- ValidIn=0 with nonzero InstrIn=0xDEADBEEF, RegWriteIn=1 → bubble: InstrOut=0, RegWriteOut=0, ValidOut=0.
